// File: rtl/acc_bank_pkg.sv
// Shared types and arithmetic helpers for the column accumulator bank.
// Helpers work on 64-bit values; callers truncate to their own widths.
package acc_bank_pkg;

    typedef enum logic {ST_ACC, ST_HOLD} acc_state_t;

    function automatic logic [63:0] sat_max(input int w, input bit sgn);
        logic [63:0] one;
        one = 64'd1;
        return sgn ? (one << (w - 1)) - 64'd1 : (one << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w, input bit sgn);
        logic [63:0] one;
        one = 64'd1;
        return sgn ? ~((one << (w - 1)) - 64'd1) : 64'd0;
    endfunction

    function automatic logic [63:0] ext(
        input logic [63:0] a,
        input int          aw,
        input int          zw,
        input bit          sgn
    );
        logic [63:0] one;
        logic [63:0] mask;
        logic [63:0] v;
        one  = 64'd1;
        mask = (one << aw) - 64'd1;
        v    = a & mask;
        if (sgn && a[aw-1])
            v = v | ~mask;
        return v & ((one << zw) - 64'd1);
    endfunction

endpackage

// File: rtl/acc_bank_if.sv
// Handshake and data bundle between the array columns, the bank and
// the readout stage.
interface acc_bank_if #(
    parameter int NUM_CH = 4,
    parameter int A_BITS = 8,
    parameter int Z_BITS = 12
);
    logic                     mode_sat;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*A_BITS-1:0] a;
    logic [NUM_CH-1:0]        clear;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*Z_BITS-1:0] z;
    logic [NUM_CH-1:0]        ovf;

    modport master (
        output mode_sat, in_valid, a, clear, out_ready,
        input  in_ready, out_valid, z, ovf
    );

    modport slave (
        input  mode_sat, in_valid, a, clear, out_ready,
        output in_ready, out_valid, z, ovf
    );
endinterface

// File: rtl/acc_bank_n_lane.sv
// One accumulator column: extend, add, overflow detect, wrap/saturate,
// plus the running-sum and sticky overflow registers.
module acc_lane
    import acc_bank_pkg::*;
#(
    parameter int A_BITS = 8,
    parameter int Z_BITS = 12,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              clear,
    input  logic              hold,
    input  logic              mode_sat,
    input  logic [A_BITS-1:0] a,
    output logic [Z_BITS-1:0] acc,
    output logic              ovf
);
    localparam bit SGN = (SIGNED != 0);

    logic [Z_BITS-1:0] ea;
    logic [Z_BITS-1:0] base;
    logic [Z_BITS-1:0] res;
    logic [Z_BITS:0]   sum;
    logic              fresh;
    logic              ov;

    always_comb begin
        fresh = load | clear;
        ea    = Z_BITS'(ext(64'(a), A_BITS, Z_BITS, SGN));
        base  = fresh ? '0 : acc;
        if (SGN)
            sum = {base[Z_BITS-1], base} + {ea[Z_BITS-1], ea};
        else
            sum = {1'b0, base} + {1'b0, ea};
        // Signed: the extra top bit is the true sign of the sum.
        ov  = SGN ? (sum[Z_BITS] != sum[Z_BITS-1]) : sum[Z_BITS];
        res = sum[Z_BITS-1:0];
        if (ov && mode_sat) begin
            if (SGN && sum[Z_BITS])
                res = Z_BITS'(sat_min(Z_BITS, SGN));
            else
                res = Z_BITS'(sat_max(Z_BITS, SGN));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (!hold || load) begin
            if (en) begin
                acc <= res;
                ovf <= (fresh ? 1'b0 : ovf) | ov;
            end else if (fresh) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/acc_bank_n.sv
// Bank of NUM_CH column accumulators summing FRAME_LEN beats per frame
// and handing the totals off under valid/ready.
module acc_bank_n
    import acc_bank_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int A_BITS    = 8,
    parameter int Z_BITS    = 12,
    parameter int FRAME_LEN = 4,
    parameter int SIGNED    = 0
) (
    input logic        clk,
    input logic        rst,
    acc_bank_if.slave  bus
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    acc_state_t               state_q;
    acc_state_t               state_d;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic                     in_ready;
    logic                     out_valid;
    logic                     accept;
    logic                     handoff;
    logic                     last;
    logic [NUM_CH*Z_BITS-1:0] z_w;
    logic [NUM_CH-1:0]        ovf_w;

    assign out_valid = (state_q == ST_HOLD);
    assign in_ready  = rst & (!out_valid | bus.out_ready);
    assign accept    = bus.in_valid & in_ready;
    assign handoff   = out_valid & bus.out_ready;
    assign last      = (cnt_q == CW'(FRAME_LEN - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.z         = z_w;
    assign bus.ovf       = ovf_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (last)
                        state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A beat taken in the handoff cycle opens the next frame.
                if (handoff) begin
                    cnt_d   = accept ? CW'(1) : '0;
                    state_d = (accept && FRAME_LEN == 1) ? ST_HOLD : ST_ACC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        acc_lane #(
            .A_BITS (A_BITS),
            .Z_BITS (Z_BITS),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (accept),
            .load     (handoff),
            .clear    (bus.clear[i] & !out_valid),
            .hold     (out_valid),
            .mode_sat (bus.mode_sat),
            .a        (bus.a[i*A_BITS +: A_BITS]),
            .acc      (z_w[i*Z_BITS +: Z_BITS]),
            .ovf      (ovf_w[i])
        );
    end

endmodule

// File: tb/tb_acc_bank_n.sv
// Scoreboard bench for acc_bank_n: default, long-frame unsigned and
// long-frame signed instances.
module tb_acc_bank_n;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int ZW = 12;

    typedef struct {
        logic [N*ZW-1:0] z;
        logic [N-1:0]    ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_bank_if #(.NUM_CH(N), .A_BITS(AW), .Z_BITS(ZW)) b0 ();
    acc_bank_if #(.NUM_CH(N), .A_BITS(AW), .Z_BITS(ZW)) b1 ();
    acc_bank_if #(.NUM_CH(N), .A_BITS(AW), .Z_BITS(ZW)) b2 ();

    acc_bank_n #(.NUM_CH(N), .A_BITS(AW), .Z_BITS(ZW),
                 .FRAME_LEN(4), .SIGNED(0))
        d0 (.clk(clk), .rst(rst), .bus(b0));
    acc_bank_n #(.NUM_CH(N), .A_BITS(AW), .Z_BITS(ZW),
                 .FRAME_LEN(20), .SIGNED(0))
        d1 (.clk(clk), .rst(rst), .bus(b1));
    acc_bank_n #(.NUM_CH(N), .A_BITS(AW), .Z_BITS(ZW),
                 .FRAME_LEN(20), .SIGNED(1))
        d2 (.clk(clk), .rst(rst), .bus(b2));

    exp_t sb[$];
    exp_t e;
    exp_t hold_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_acc[N];
    bit   m_ovf[N];
    int   m_cnt;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*AW-1:0] pk(int x0, int x1, int x2, int x3);
        return {AW'(x3), AW'(x2), AW'(x1), AW'(x0)};
    endfunction

    function automatic logic [N*ZW-1:0] m_z();
        logic [N*ZW-1:0] v;
        for (int i = 0; i < N; i++)
            v[i*ZW +: ZW] = ZW'(m_acc[i]);
        return v;
    endfunction

    function automatic logic [N-1:0] m_o();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++)
            v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    // Unsigned 12-bit reference in plain integer arithmetic.
    task automatic m_lane(int i, int av, bit clr, bit sat);
        int s;
        bit ov;
        s  = (clr ? 0 : m_acc[i]) + av;
        ov = (s >= 4096);
        if (ov)
            s = sat ? 4095 : s - 4096;
        m_acc[i] = s;
        m_ovf[i] = (clr ? 1'b0 : m_ovf[i]) | ov;
    endtask

    task automatic beat(input logic [N*AW-1:0] av,
                        input logic [N-1:0] clr, input bit sat);
        b0.in_valid = 1'b1;
        b0.a        = av;
        b0.clear    = clr;
        b0.mode_sat = sat;
        for (int i = 0; i < N; i++)
            m_lane(i, int'(av[i*AW +: AW]), clr[i], sat);
        m_cnt++;
        if (m_cnt == 4) begin
            sb.push_back('{m_z(), m_o()});
            m_reset();
        end
        step();
        b0.in_valid = 1'b0;
        b0.clear    = '0;
    endtask

    always @(negedge clk) begin
        if (rst && b0.out_valid && b0.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_empty: frame seen, none expected");
            end else begin
                e = sb.pop_front();
                chk("frame_z", 64'(b0.z), 64'(e.z));
                chk("frame_ovf", 64'(b0.ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        b0.in_valid = 0; b0.a = '0; b0.clear = '0;
        b0.mode_sat = 0; b0.out_ready = 1;
        b1.in_valid = 0; b1.a = '0; b1.clear = '0;
        b1.mode_sat = 0; b1.out_ready = 1;
        b2.in_valid = 0; b2.a = '0; b2.clear = '0;
        b2.mode_sat = 0; b2.out_ready = 1;
        m_reset();

        #2 rst = 1'b0;
        #1;
        chk("rst_z", 64'(b0.z), 0);
        chk("rst_ovf", 64'(b0.ovf), 0);
        chk("rst_ov", 64'(b0.out_valid), 0);
        chk("rst_ir", 64'(b0.in_ready), 0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("acc_ir", 64'(b0.in_ready), 1);

        // basic unsigned frame, independent lanes
        beat(pk(10, 1, 200, 255), '0, 0);
        beat(pk(20, 2, 200, 255), '0, 0);
        beat(pk(30, 3, 200, 255), '0, 0);
        chk("ov_early", 64'(b0.out_valid), 0);
        beat(pk(40, 4, 200, 255), '0, 0);
        chk("ov_lat", 64'(b0.out_valid), 1);
        chk("z0_100", 64'(b0.z[ZW-1:0]), 100);
        step();
        chk("ov_drop", 64'(b0.out_valid), 0);
        chk("z_zero", 64'(b0.z), 0);

        // clear with a beat, and clear in an idle cycle
        beat(pk(1, 2, 50, 4), '0, 1);
        beat(pk(1, 2, 50, 4), '0, 1);
        beat(pk(1, 2, 7, 4), 4'b0100, 1);
        beat(pk(1, 2, 3, 4), '0, 1);
        chk("clr_ov", 64'(b0.out_valid), 1);
        chk("clr_z2", 64'(b0.z[2*ZW +: ZW]), 10);
        step();
        beat(pk(9, 9, 9, 9), '0, 0);
        b0.clear = 4'b0001;
        m_acc[0] = 0;
        m_ovf[0] = 1'b0;
        step();
        b0.clear = '0;
        beat(pk(1, 1, 1, 1), '0, 0);
        beat(pk(1, 1, 1, 1), '0, 0);
        beat(pk(1, 1, 1, 1), '0, 0);
        chk("clr_cnt", 64'(b0.out_valid), 1);
        step();

        // back-pressure, then handoff with a beat in the same cycle
        b0.out_ready = 1'b0;
        beat(pk(11, 22, 33, 44), '0, 0);
        beat(pk(11, 22, 33, 44), '0, 0);
        beat(pk(11, 22, 33, 44), '0, 0);
        beat(pk(11, 22, 33, 44), '0, 0);
        hold_e = sb[sb.size()-1];
        for (int k = 0; k < 3; k++) begin
            b0.in_valid = 1'b1;
            b0.a        = pk(99, 99, 99, 99);
            b0.clear    = 4'hf;
            chk("bp_ir", 64'(b0.in_ready), 0);
            step();
            chk("bp_ov", 64'(b0.out_valid), 1);
            chk("bp_z", 64'(b0.z), 64'(hold_e.z));
            chk("bp_ovf", 64'(b0.ovf), 64'(hold_e.ovf));
        end
        b0.in_valid  = 1'b0;
        b0.clear     = '0;
        b0.out_ready = 1'b1;
        beat(pk(5, 5, 5, 5), '0, 0);
        chk("hs_ov", 64'(b0.out_valid), 0);
        chk("hs_z", 64'(b0.z), 64'({4{12'd5}}));
        beat(pk(5, 5, 5, 5), '0, 0);
        beat(pk(5, 5, 5, 5), '0, 0);
        beat(pk(5, 5, 5, 5), '0, 0);
        chk("hs_cnt1", 64'(b0.out_valid), 1);
        step();

        // long frames: unsigned lane 1 and signed all lanes, sat then wrap
        for (int s = 1; s >= 0; s--) begin
            b1.mode_sat = s[0];
            b2.mode_sat = s[0];
            b1.out_ready = s[0];
            b2.out_ready = s[0];
            b1.a = pk(0, 255, 1, 0);
            b2.a = {4{8'h80}};
            b1.in_valid = 1'b1;
            b2.in_valid = 1'b1;
            for (int k = 0; k < 20; k++) begin
                if (k == 19)
                    chk("lf_early", 64'(b1.out_valid), 0);
                step();
            end
            b1.in_valid = 1'b0;
            b2.in_valid = 1'b0;
            chk("lf_ov", 64'(b1.out_valid), 1);
            chk("lf_z1", 64'(b1.z[ZW +: ZW]), s ? 4095 : 1004);
            chk("lf_z2", 64'(b1.z[2*ZW +: ZW]), 20);
            chk("lf_ovf", 64'(b1.ovf), 4'b0010);
            chk("sg_ov", 64'(b2.out_valid), 1);
            chk("sg_z", 64'(b2.z), s ? 64'({4{12'h800}}) : 64'({4{12'h600}}));
            chk("sg_ovf", 64'(b2.ovf), 4'hf);
            if (s == 1) begin
                step();
                chk("lf_drop", 64'(b1.out_valid), 0);
                chk("lf_clr", 64'(b1.z), 0);
            end
        end

        // reset while holding totals
        b0.out_ready = 1'b0;
        beat(pk(2, 2, 2, 2), '0, 0);
        beat(pk(2, 2, 2, 2), '0, 0);
        beat(pk(2, 2, 2, 2), '0, 0);
        beat(pk(2, 2, 2, 2), '0, 0);
        chk("rh_pre", 64'(b0.out_valid), 1);
        rst = 1'b0;
        #1;
        chk("rh_z", 64'(b0.z), 0);
        chk("rh_ov", 64'(b0.out_valid), 0);
        chk("rh_ir", 64'(b0.in_ready), 0);
        chk("rh_ovf1", 64'(b1.ovf), 0);
        chk("rh_z2", 64'(b2.z), 0);
        chk("rh_ov2", 64'(b2.out_valid), 0);
        sb.delete();
        m_reset();
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        step();
        rst = 1'b1;

        // reset mid-frame, then a clean frame from zero
        beat(pk(3, 3, 3, 3), '0, 0);
        beat(pk(3, 3, 3, 3), '0, 0);
        rst = 1'b0;
        #1;
        chk("rf_z", 64'(b0.z), 0);
        chk("rf_ir", 64'(b0.in_ready), 0);
        m_reset();
        step();
        rst = 1'b1;
        beat(pk(6, 7, 8, 9), '0, 0);
        beat(pk(6, 7, 8, 9), '0, 0);
        beat(pk(6, 7, 8, 9), '0, 0);
        beat(pk(6, 7, 8, 9), '0, 0);
        chk("rf_ov", 64'(b0.out_valid), 1);
        chk("rf_z0", 64'(b0.z[ZW-1:0]), 24);
        step();
        chk("sb_drain", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
